acc_requant_drain: RTL and testbench
====================================

# acc_requant_drain

Drains one row of 32-bit systolic-array accumulators into the activation path. It sits directly downstream of the MAC processing elements. It captures a vector of `NUM_COLS` accumulators plus their sticky overflow flags in one handshake. It then serialises them one column per cycle through a 3-stage bias → scale → round/clamp pipeline and emits signed 8-bit activations, ready for the next layer's input buffer, on a valid/ready stream.

## Interface
Parameters:
- `NUM_COLS`, 8: accumulators per captured vector.
- `ACC_WIDTH`, 32: accumulator/bias width.
- `OUT_WIDTH`, 8: output activation width.
- `MULT_WIDTH`, 16: unsigned requant multiplier width.
- `SHIFT_WIDTH`, 5: right-shift amount width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all logic is posedge.
- `rst`  in  1  synchronous active-high reset.
- `acc_valid`  in  1  accumulator vector valid.
- `acc_ready`  out  1  block can accept a vector.
- `acc_data`  in  NUM_COLS*ACC_WIDTH  signed accumulators; column c is at `[c*ACC_WIDTH +: ACC_WIDTH]`.
- `acc_ovf`  in  NUM_COLS  per-column sticky overflow from the PEs.
- `bias_data`  in  NUM_COLS*ACC_WIDTH  signed per-column bias.
- `cfg_mult`  in  MULT_WIDTH  unsigned multiplier.
- `cfg_shift`  in  SHIFT_WIDTH  arithmetic right shift, 0..31.
- `cfg_zero_point`  in  OUT_WIDTH  signed output zero point.
- `cfg_relu_en`  in  1  clamp the lower bound to the zero point.
- `out_valid`  out  1  output element valid.
- `out_ready`  in  1  consumer accepts the element.
- `out_data`  out  OUT_WIDTH  signed requantised activation.
- `out_col`  out  $clog2(NUM_COLS)  column index of `out_data`.
- `out_last`  out  1  high with column NUM_COLS-1.
- `out_sat`  out  1  element was saturated or overflow-tainted.
- `busy`  out  1  FSM is in DRAIN or any pipeline stage is valid.
- `sat_count`  out  16  count of accepted outputs with `out_sat`=1; saturates at 0xFFFF.

## Operation
- FSM `IDLE` → `DRAIN` → `IDLE`.
  - `acc_ready` = 1 only in IDLE.
  - An `acc_valid && acc_ready` edge latches `acc_data`, `acc_ovf`, `bias_data` and all `cfg_*` into shadow registers. Config changes while a vector is in flight have no effect on that vector.
- In DRAIN, column counter `col` (0..NUM_COLS-1) issues one column into S1 per advancing cycle.
  - After issuing NUM_COLS-1, `col` wraps to 0 and the FSM returns to IDLE.
- Pipeline advance = `!out_valid || out_ready`. When it is low, every stage and `col` hold.
- S1: 33-bit signed `acc + bias`, saturated to 32 bits. Saturation ORs with `acc_ovf[col]` into the lane's sat flag.
- S2: signed 32 × zero-extended unsigned 16 → 49-bit signed product.
- S3:
  - Rounding add: `1 << (shift-1)` when shift > 0 (see Configuration).
  - Arithmetic `>>> shift`.
  - Add sign-extended zero point.
  - Clamp to [lo, 127], where lo = -128, or lo = zero_point when `cfg_relu_en`.
  - Any upper/lower clamp (the ReLU clamp excluded) sets sat.
- S3 is the output register.
- `sat_count` increments on each `out_valid && out_ready && out_sat`.

## Timing
- Reset values: `acc_ready`=1, `out_valid`=0, `out_data`=0, `out_col`=0, `out_last`=0, `out_sat`=0, `busy`=0, `sat_count`=0. FSM = IDLE, `col`=0, all stage valids 0.
- Acc handshake at edge E → column 0 is visible at the output after edge E+3 (S1 loads at E+1, S2 at E+2, S3 at E+3). With no backpressure, columns follow on consecutive cycles.
- `acc_ready` rises the cycle after the last column is issued. Vector throughput is one per NUM_COLS+1 cycles.
- `out_data`/`out_col`/`out_last`/`out_sat` stay stable while `out_valid && !out_ready`.
- `rst` mid-drain: the next cycle shows reset values and the in-flight data is discarded.

## Configuration
- Macro `REQUANT_ROUND_EN`:
  - Defined: S3 adds the half-LSB before shifting (round-half-up).
  - Undefined: no add, plain floor shift. S3 logic is otherwise identical and latency is unchanged.

## Structure
- Add `OUT_WIDTH`, `REQ_MULT_WIDTH`, `REQ_SHIFT_WIDTH` to `pkg_accelerator`, alongside the existing `ACC_WIDTH`/`ACT_WIDTH`.
- Also add to `pkg_accelerator`: `typedef struct packed requant_cfg_t` (mult, shift, zero_point, relu_en) and `typedef enum drain_state_e {IDLE, DRAIN}`.
- One sub-module, `requant_lane`: S1–S3 arithmetic with stage valids and a shared advance enable. The top holds the FSM, shadow registers, column mux and counters.

## Test plan
- Identity: mult=1, shift=0, zp=0, bias=0, acc={0,1,-1,127,-128,5,-5,100} → identical outputs. `out_col` runs 0..7, `out_last` is high only on col 7, the first `out_valid` appears at E+3, and `sat_count` stays 0.
- Rounding: mult=1, shift=2, acc=6 → 2 and acc=-6 → -1 with `REQUANT_ROUND_EN`; without it → 1 and -2.
- Saturation and overflow:
  - acc=1000 → 127 with `out_sat`=1.
  - acc=-1000 → -128 with `out_sat`=1.
  - acc=0x7FFFFFF0 with bias=0x100 saturates in S1 → `out_sat`=1.
  - `acc_ovf[2]`=1 with acc=3 → col 2 outputs 3 with `out_sat`=1.
  - `sat_count` equals the number of sat-flagged outputs accepted.
- ReLU: relu_en=1, zp=10, mult=1, shift=0: acc=-50 → 10 with `out_sat`=0; acc=20 → 30.
- Backpressure: `out_ready`=0 for 4 cycles mid-drain → outputs are held stable, all 8 columns are delivered exactly once in order, and `acc_ready` stays 0 until the last column is issued.
- Reset mid-drain: assert `rst` while col 3 is output → the next cycle shows `out_valid`=0, `acc_ready`=1, `sat_count`=0, `busy`=0. A new vector then drains correctly from col 0.

Source files
------------

// File: rtl/pkg_accelerator.sv
// Shared accelerator constants and types.
// Requantisation widths, the per-vector requant configuration bundle and
// the drain FSM state encoding used by acc_requant_drain / requant_lane.
package pkg_accelerator;

    localparam int ACC_WIDTH       = 32;
    localparam int ACT_WIDTH       = 8;
    localparam int OUT_WIDTH       = ACT_WIDTH;
    localparam int REQ_MULT_WIDTH  = 16;
    localparam int REQ_SHIFT_WIDTH = 5;

    // Requant settings captured with each accumulator vector.
    typedef struct packed {
        logic [REQ_MULT_WIDTH-1:0]  mult;        // unsigned multiplier
        logic [REQ_SHIFT_WIDTH-1:0] shift;       // arithmetic right shift
        logic [OUT_WIDTH-1:0]       zero_point;  // signed output zero point
        logic                       relu_en;     // lower clamp at zero point
    } requant_cfg_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/requant_lane.sv
// Three-stage requantisation lane: S1 bias add with 32-bit saturation,
// S2 multiply by the unsigned requant multiplier, S3 round/shift, zero-point
// add and clamp into the output register. All stages share one advance
// enable; each stage carries the config it needs so a following vector's
// config never leaks into elements still in flight.
// Build option: REQUANT_ROUND_EN adds the half-LSB before the shift.
//
// Handshake: an element moves stage to stage only when adv is high
// (adv = !out_valid || out_ready, computed by the parent); when adv is low
// every stage, including the output register, holds its contents.
module requant_lane
    import pkg_accelerator::*;
#(
    parameter int COL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 in_valid,
    input  logic [ACC_WIDTH-1:0] in_acc,
    input  logic [ACC_WIDTH-1:0] in_bias,
    input  logic                 in_ovf,
    input  logic [COL_WIDTH-1:0] in_col,
    input  logic                 in_last,
    input  requant_cfg_t         in_cfg,
    output logic                 s1_valid,
    output logic                 s2_valid,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [COL_WIDTH-1:0] out_col,
    output logic                 out_last,
    output logic                 out_sat
);

    localparam int PW = ACC_WIDTH + REQ_MULT_WIDTH + 1;
    localparam logic signed [PW:0] HI = (PW+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [PW:0] LO = (PW+1)'(-(2**(OUT_WIDTH-1)));

    logic signed [ACC_WIDTH:0]   sum;
    logic                        sum_ovf;
    logic [ACC_WIDTH-1:0]        sum_sat;

    logic [ACC_WIDTH-1:0]        s1_val;
    logic                        s1_sat;
    logic [COL_WIDTH-1:0]        s1_col;
    logic                        s1_last;
    requant_cfg_t                s1_cfg;

    logic signed [PW-1:0]        s2_prod;
    logic                        s2_sat;
    logic [COL_WIDTH-1:0]        s2_col;
    logic                        s2_last;
    logic [REQ_SHIFT_WIDTH-1:0]  s2_shift;
    logic [OUT_WIDTH-1:0]        s2_zp;
    logic                        s2_relu;

    logic signed [PW-1:0]        rnd;
    logic signed [PW-1:0]        rounded;
    logic signed [PW-1:0]        shifted;
    logic signed [PW:0]          with_zp;
    logic signed [PW:0]          zp_ext;
    logic [OUT_WIDTH-1:0]        res;
    logic                        res_sat;

    // S1 combinational: 33-bit add, saturate back to 32 bits
    always_comb begin
        sum     = (ACC_WIDTH+1)'($signed(in_acc)) + (ACC_WIDTH+1)'($signed(in_bias));
        sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        sum_sat = sum[ACC_WIDTH-1:0];
        if (sum_ovf) begin
            sum_sat = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    // S3 combinational: optional rounding, shift, zero point, clamp
    always_comb begin
        rnd = '0;
`ifdef REQUANT_ROUND_EN
        if (s2_shift != '0) begin
            rnd = PW'(1) << (s2_shift - 1'b1);
        end
`endif
        rounded = s2_prod + rnd;
        shifted = rounded >>> s2_shift;
        zp_ext  = (PW+1)'($signed(s2_zp));
        with_zp = (PW+1)'(shifted) + zp_ext;
        res     = with_zp[OUT_WIDTH-1:0];
        res_sat = s2_sat;
        if (with_zp > HI) begin
            res     = HI[OUT_WIDTH-1:0];
            res_sat = 1'b1;
        end else if (s2_relu && (with_zp < zp_ext)) begin
            res     = s2_zp;      // ReLU floor is not a saturation event
        end else if (with_zp < LO) begin
            res     = LO[OUT_WIDTH-1:0];
            res_sat = 1'b1;
        end
    end

    // Stage registers, all gated by the shared advance enable
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_val    <= '0;
            s1_sat    <= 1'b0;
            s1_col    <= '0;
            s1_last   <= 1'b0;
            s1_cfg    <= '0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_sat    <= 1'b0;
            s2_col    <= '0;
            s2_last   <= 1'b0;
            s2_shift  <= '0;
            s2_zp     <= '0;
            s2_relu   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (in_valid) begin
                s1_val  <= sum_sat;
                s1_sat  <= sum_ovf | in_ovf;
                s1_col  <= in_col;
                s1_last <= in_last;
                s1_cfg  <= in_cfg;
            end
            if (s1_valid) begin
                s2_prod  <= PW'($signed(s1_val)) * PW'($signed({1'b0, s1_cfg.mult}));
                s2_sat   <= s1_sat;
                s2_col   <= s1_col;
                s2_last  <= s1_last;
                s2_shift <= s1_cfg.shift;
                s2_zp    <= s1_cfg.zero_point;
                s2_relu  <= s1_cfg.relu_en;
            end
            if (s2_valid) begin
                out_data <= res;
                out_col  <= s2_col;
                out_last <= s2_last;
                out_sat  <= res_sat;
            end
        end
    end

endmodule

// File: rtl/acc_requant_drain.sv
// Accumulator row drain: captures a vector of NUM_COLS accumulators, their
// overflow flags, biases and requant config in one handshake, then feeds one
// column per advancing cycle into requant_lane and counts saturated outputs.
// Build option: REQUANT_ROUND_EN (round-half-up inside requant_lane).
//
// Handshakes: acc side transfers on acc_valid && acc_ready (ready only in
// IDLE); out side transfers on out_valid && out_ready, and out_* hold
// steady while out_valid && !out_ready.
module acc_requant_drain #(
    parameter int NUM_COLS    = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 8,
    parameter int MULT_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          acc_valid,
    output logic                          acc_ready,
    input  logic [NUM_COLS*ACC_WIDTH-1:0] acc_data,
    input  logic [NUM_COLS-1:0]           acc_ovf,
    input  logic [NUM_COLS*ACC_WIDTH-1:0] bias_data,
    input  logic [MULT_WIDTH-1:0]         cfg_mult,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic [OUT_WIDTH-1:0]          cfg_zero_point,
    input  logic                          cfg_relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_COLS)-1:0]   out_col,
    output logic                          out_last,
    output logic                          out_sat,
    output logic                          busy,
    output logic [15:0]                   sat_count,
    output logic                          state_dbg
);

    import pkg_accelerator::requant_cfg_t;
    import pkg_accelerator::drain_state_e;
    import pkg_accelerator::IDLE;
    import pkg_accelerator::DRAIN;

    localparam int            CW       = $clog2(NUM_COLS);
    localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);

    drain_state_e                  state_q, state_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [NUM_COLS*ACC_WIDTH-1:0] acc_sh, bias_sh;
    logic [NUM_COLS-1:0]           ovf_sh;
    requant_cfg_t                  cfg_sh;
    logic                          adv, issue, accept;
    logic                          s1_valid, s2_valid;

    assign adv       = !out_valid || out_ready;
    assign accept    = acc_valid && acc_ready;
    assign busy      = (state_q == DRAIN) || s1_valid || s2_valid || out_valid;
    assign state_dbg = (state_q == DRAIN);

    // Next-state, column counter and issue decode
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        acc_ready = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                acc_ready = 1'b1;
                if (acc_valid) state_d = DRAIN;
            end
            DRAIN: begin
                if (adv) begin
                    issue = 1'b1;
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and column register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Shadow copy of the vector and its config, taken on the acc handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sh  <= '0;
            bias_sh <= '0;
            ovf_sh  <= '0;
            cfg_sh  <= '0;
        end else if (accept) begin
            acc_sh             <= acc_data;
            bias_sh            <= bias_data;
            ovf_sh             <= acc_ovf;
            cfg_sh.mult        <= cfg_mult;
            cfg_sh.shift       <= cfg_shift;
            cfg_sh.zero_point  <= cfg_zero_point;
            cfg_sh.relu_en     <= cfg_relu_en;
        end
    end

    // Saturated-output counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    requant_lane #(
        .COL_WIDTH (CW)
    ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .in_valid  (issue),
        .in_acc    (acc_sh[col_q*ACC_WIDTH +: ACC_WIDTH]),
        .in_bias   (bias_sh[col_q*ACC_WIDTH +: ACC_WIDTH]),
        .in_ovf    (ovf_sh[col_q]),
        .in_col    (col_q),
        .in_last   (col_q == LAST_COL),
        .in_cfg    (cfg_sh),
        .s1_valid  (s1_valid),
        .s2_valid  (s2_valid),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_sat   (out_sat)
    );

endmodule

// File: tb/tb_acc_requant_drain.sv
// Self-checking bench for acc_requant_drain. Expected outputs come from a
// plain-arithmetic model of the requant rules; observed outputs are
// collected by a negedge monitor and compared in order per scenario.
module tb_acc_requant_drain;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int MW = 16;
    localparam int SW = 5;
    localparam int CW = 3;
    localparam int EW = 1 + 1 + CW + OW;   // {sat, last, col, data}
    localparam longint MAX32 = 64'sd2147483647;
    localparam longint MIN32 = -64'sd2147483648;
`ifdef REQUANT_ROUND_EN
    localparam int R_POS = 2;
    localparam int R_NEG = -1;
`else
    localparam int R_POS = 1;
    localparam int R_NEG = -2;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            acc_valid, acc_ready;
    logic [N*AW-1:0] acc_data, bias_data;
    logic [N-1:0]    acc_ovf;
    logic [MW-1:0]   cfg_mult;
    logic [SW-1:0]   cfg_shift;
    logic [OW-1:0]   cfg_zero_point;
    logic            cfg_relu_en;
    logic            out_valid, out_ready;
    logic [OW-1:0]   out_data;
    logic [CW-1:0]   out_col;
    logic            out_last, out_sat, busy, state_dbg;
    logic [15:0]     sat_count;

    acc_requant_drain dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .acc_ovf(acc_ovf), .bias_data(bias_data),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zero_point(cfg_zero_point),
        .cfg_relu_en(cfg_relu_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col), .out_last(out_last), .out_sat(out_sat),
        .busy(busy), .sat_count(sat_count), .state_dbg(state_dbg)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs_cyc;
    int exp_sat = 0;
    bit rnd_ready_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    int            obs_t[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_q.push_back({out_sat, out_last, out_col, out_data});
            obs_t.push_back(cyc);
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready_on) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // stimulus staging and reference model
    int       v_acc[N];
    int       v_bias[N];
    logic [N-1:0] v_ovf;
    int       c_mult, c_shift, c_zp;
    bit       c_relu;

    function automatic logic [EW-1:0] model(int acc, int bias, bit ovf, int col);
        longint s, p, v;
        bit sat;
        s = longint'(acc) + longint'(bias);
        sat = ovf;
        if (s > MAX32) begin s = MAX32; sat = 1'b1; end
        else if (s < MIN32) begin s = MIN32; sat = 1'b1; end
        p = s * longint'(c_mult);
`ifdef REQUANT_ROUND_EN
        if (c_shift > 0) p = p + (longint'(1) << (c_shift - 1));
`endif
        v = (p >>> c_shift) + longint'(c_zp);
        if (v > 127) begin v = 127; sat = 1'b1; end
        else if (c_relu && v < c_zp) v = c_zp;
        else if (v < -128) begin v = -128; sat = 1'b1; end
        return {sat, 1'(col == N - 1), 3'(col), 8'(v)};
    endfunction

    task automatic set_cfg(int m, int s, int z, bit r);
        c_mult = m; c_shift = s; c_zp = z; c_relu = r;
    endtask

    task automatic rand_vec(int lo, int hi);
        for (int c = 0; c < N; c++) begin
            v_acc[c]  = int'($urandom_range(0, hi - lo)) + lo;
            v_bias[c] = 0;
        end
        v_ovf = '0;
    endtask

    // driver: present a vector and hold it until accepted
    task automatic send_vector();
        bit ok = 1'b0;
        @(negedge clk);
        for (int c = 0; c < N; c++) begin
            acc_data[c*AW +: AW]  = v_acc[c];
            bias_data[c*AW +: AW] = v_bias[c];
        end
        acc_ovf        = v_ovf;
        cfg_mult       = c_mult[MW-1:0];
        cfg_shift      = c_shift[SW-1:0];
        cfg_zero_point = c_zp[OW-1:0];
        cfg_relu_en    = c_relu;
        acc_valid      = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (acc_ready) begin
                @(posedge clk); #1;
                hs_cyc = cyc;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        acc_valid = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL send_vector acc_ready got=0 exp=1 within 200 cycles");
        end else begin
            for (int c = 0; c < N; c++) exp_q.push_back(model(v_acc[c], v_bias[c], v_ovf[c], c));
        end
        // disturb the inputs after capture; the in-flight vector must not see this
        cfg_mult = 16'($urandom); cfg_shift = 5'($urandom);
        cfg_zero_point = 8'($urandom); cfg_relu_en = 1'($urandom);
        acc_ovf = 8'($urandom);
        for (int c = 0; c < N; c++) begin
            acc_data[c*AW +: AW]  = $urandom;
            bias_data[c*AW +: AW] = $urandom;
        end
    endtask

    task automatic wait_outputs(int n);
        int i = 0;
        while (obs_q.size() < n && i < 1000) begin
            @(posedge clk); #1;
            i++;
        end
        total++;
        if (obs_q.size() < n) begin
            bad++;
            $display("FAIL wait_outputs count got=%0d exp=%0d", obs_q.size(), n);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete(); obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total += 8;
        if (acc_ready !== 1'b1) begin bad++; $display("FAIL reset acc_ready got=%b exp=1", acc_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
        if (out_data !== 8'd0)  begin bad++; $display("FAIL reset out_data got=%h exp=0", out_data); end
        if (out_col !== 3'd0)   begin bad++; $display("FAIL reset out_col got=%0d exp=0", out_col); end
        if (out_last !== 1'b0)  begin bad++; $display("FAIL reset out_last got=%b exp=0", out_last); end
        if (out_sat !== 1'b0)   begin bad++; $display("FAIL reset out_sat got=%b exp=0", out_sat); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
        if (sat_count !== 16'd0) begin bad++; $display("FAIL reset sat_count got=%0d exp=0", sat_count); end
        exp_sat = 0;
    endtask

    task automatic test_identity();
        int ident[N] = '{0, 1, -1, 127, -128, 5, -5, 100};
        logic [EW-1:0] e, o;
        clear_sb();
        set_cfg(1, 0, 0, 1'b0);
        for (int c = 0; c < N; c++) begin v_acc[c] = ident[c]; v_bias[c] = 0; end
        v_ovf = '0;
        send_vector();
        wait_outputs(N);
        total++;
        if (obs_t.size() == 0 || obs_t[0] !== hs_cyc + 3) begin
            bad++;
            $display("FAIL identity first_latency got=%0d exp=%0d", (obs_t.size() > 0) ? obs_t[0] - hs_cyc : -1, 3);
        end
        for (int c = 0; c < N && c < obs_q.size(); c++) begin
            total++;
            if (obs_q[c] !== {1'b0, 1'(c == N - 1), 3'(c), 8'(ident[c])}) begin
                bad++; $display("FAIL identity col%0d got=%h exp=%h", c, obs_q[c], {1'b0, 1'(c == N - 1), 3'(c), 8'(ident[c])});
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL identity model got=%h exp=%h", o, e); end
        end
        total++;
        if (sat_count !== 16'd0) begin bad++; $display("FAIL identity sat_count got=%0d exp=0", sat_count); end
    endtask

    task automatic test_rounding();
        logic [EW-1:0] e, o;
        clear_sb();
        set_cfg(1, 2, 0, 1'b0);
        rand_vec(-1000, 1000);
        v_acc[0] = 6; v_acc[1] = -6;
        send_vector();
        wait_outputs(N);
        total += 2;
        if (obs_q[0][OW-1:0] !== 8'(R_POS)) begin bad++; $display("FAIL rounding pos got=%0d exp=%0d", $signed(obs_q[0][OW-1:0]), R_POS); end
        if (obs_q[1][OW-1:0] !== 8'(R_NEG)) begin bad++; $display("FAIL rounding neg got=%0d exp=%0d", $signed(obs_q[1][OW-1:0]), R_NEG); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL rounding model got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_saturation();
        logic [EW-1:0] e, o;
        clear_sb();
        set_cfg(1, 0, 0, 1'b0);
        rand_vec(-300, 300);
        v_acc[0] = 1000; v_acc[1] = -1000;
        v_acc[2] = 3;    v_ovf[2] = 1'b1;
        v_acc[3] = 32'h7FFF_FFF0; v_bias[3] = 32'h100;
        send_vector();
        wait_outputs(N);
        total += 4;
        if (obs_q[0][EW-1] !== 1'b1 || obs_q[0][OW-1:0] !== 8'd127) begin bad++; $display("FAIL sat_hi got=%h exp sat=1 data=7f", obs_q[0]); end
        if (obs_q[1][EW-1] !== 1'b1 || obs_q[1][OW-1:0] !== 8'h80) begin bad++; $display("FAIL sat_lo got=%h exp sat=1 data=80", obs_q[1]); end
        if (obs_q[2][EW-1] !== 1'b1 || obs_q[2][OW-1:0] !== 8'd3) begin bad++; $display("FAIL sat_ovf got=%h exp sat=1 data=03", obs_q[2]); end
        if (obs_q[3][EW-1] !== 1'b1) begin bad++; $display("FAIL sat_s1 got=%h exp sat=1", obs_q[3]); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL saturation model got=%h exp=%h", o, e); end
        end
        @(negedge clk);
        total++;
        if (sat_count !== 16'(exp_sat)) begin bad++; $display("FAIL saturation sat_count got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    task automatic test_relu();
        logic [EW-1:0] e, o;
        clear_sb();
        set_cfg(1, 0, 10, 1'b1);
        rand_vec(-200, 200);
        v_acc[0] = -50; v_acc[1] = 20;
        send_vector();
        wait_outputs(N);
        total += 2;
        if (obs_q[0][EW-1] !== 1'b0 || obs_q[0][OW-1:0] !== 8'd10) begin bad++; $display("FAIL relu_floor got=%h exp sat=0 data=0a", obs_q[0]); end
        if (obs_q[1][OW-1:0] !== 8'd30) begin bad++; $display("FAIL relu_pass got=%0d exp=30", obs_q[1][OW-1:0]); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL relu model got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e, o;
        int i = 0;
        clear_sb();
        set_cfg($urandom_range(1, 200), $urandom_range(0, 8), $urandom_range(0, 255) - 128, 1'($urandom));
        rand_vec(-5000, 5000);
        send_vector();
        while (obs_q.size() < 2 && i < 100) begin @(posedge clk); #1; i++; end
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total += 3;
            if (out_valid !== 1'b1) begin bad++; $display("FAIL stall out_valid got=%b exp=1", out_valid); end
            if ({out_sat, out_last, out_col, out_data} !== exp_q[obs_q.size()]) begin
                bad++; $display("FAIL stall hold got=%h exp=%h", {out_sat, out_last, out_col, out_data}, exp_q[obs_q.size()]);
            end
            if (acc_ready !== 1'b0) begin bad++; $display("FAIL stall acc_ready got=%b exp=0", acc_ready); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        while (obs_q.size() < 4 && i < 200) begin
            @(negedge clk);
            i++;
            total++;
            if (obs_q.size() < 4 && acc_ready !== 1'b0) begin bad++; $display("FAIL drain acc_ready got=%b exp=0", acc_ready); end
        end
        wait_outputs(N);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (obs_q.size() != N) begin bad++; $display("FAIL backpressure count got=%0d exp=%0d", obs_q.size(), N); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL backpressure model got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] e, o;
        int hs1;
        clear_sb();
        set_cfg($urandom_range(1, 500), $urandom_range(0, 12), $urandom_range(0, 255) - 128, 1'b0);
        rand_vec(-100000, 100000);
        send_vector();
        hs1 = hs_cyc;
        set_cfg($urandom_range(1, 500), $urandom_range(0, 12), $urandom_range(0, 255) - 128, 1'b1);
        rand_vec(-100000, 100000);
        send_vector();
        total++;
        if (hs_cyc - hs1 != N + 1) begin bad++; $display("FAIL back_to_back spacing got=%0d exp=%0d", hs_cyc - hs1, N + 1); end
        wait_outputs(2 * N);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL back_to_back model got=%h exp=%h", o, e); end
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e, o;
        clear_sb();
        rnd_ready_on = 1'b1;
        for (int v = 0; v < 5; v++) begin
            set_cfg($urandom_range(0, 65535), $urandom_range(0, 31), $urandom_range(0, 255) - 128, 1'($urandom));
            for (int c = 0; c < N; c++) begin
                v_acc[c]  = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 40000)) - 20000;
                v_bias[c] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
            end
            v_ovf = 8'($urandom);
            send_vector();
        end
        wait_outputs(5 * N);
        rnd_ready_on = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL random model got=%h exp=%h", o, e); end
        end
        @(negedge clk);
        total++;
        if (sat_count !== 16'(exp_sat)) begin bad++; $display("FAIL random sat_count got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    task automatic test_reset_mid_drain();
        logic [EW-1:0] e, o;
        bit seen = 1'b0;
        clear_sb();
        set_cfg(1, 0, 0, 1'b0);
        rand_vec(-100, 100);
        v_acc[0] = 1000;
        send_vector();
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_col == 3'd3) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL mid_reset col3 got=0 exp=1 (never shown)"); end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0)  begin bad++; $display("FAIL mid_reset out_valid got=%b exp=0", out_valid); end
        if (acc_ready !== 1'b1)  begin bad++; $display("FAIL mid_reset acc_ready got=%b exp=1", acc_ready); end
        if (sat_count !== 16'd0) begin bad++; $display("FAIL mid_reset sat_count got=%0d exp=0", sat_count); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL mid_reset busy got=%b exp=0", busy); end
        clear_sb();
        exp_sat = 0;
        set_cfg($urandom_range(1, 50), $urandom_range(0, 4), $urandom_range(0, 255) - 128, 1'b0);
        rand_vec(-2000, 2000);
        send_vector();
        wait_outputs(N);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); void'(obs_t.pop_front());
            total++; if (e[EW-1]) exp_sat++;
            if (o !== e) begin bad++; $display("FAIL mid_reset model got=%h exp=%h", o, e); end
        end
        @(negedge clk);
        total++;
        if (sat_count !== 16'(exp_sat)) begin bad++; $display("FAIL mid_reset sat_count_after got=%0d exp=%0d", sat_count, exp_sat); end
    endtask

    initial begin
        rst = 1'b1;
        acc_valid = 1'b0;
        acc_data = '0;
        bias_data = '0;
        acc_ovf = '0;
        cfg_mult = '0;
        cfg_shift = '0;
        cfg_zero_point = '0;
        cfg_relu_en = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_relu();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
